// File: rtl/sn74_sync_pkg.sv
// Shared types and limits for the synchronous SN74-family counter models.
package sn74_sync_pkg;

    typedef logic [3:0] count4_t;

    localparam int MAX_SYNC_STAGES = 3;

endpackage

// File: rtl/ttl_fall_detect.sv
// Samples a TTL pin on the driving clock: optional synchronizer, then a registered falling-edge pulse.
// The pulse follows the synchronized level by one cycle, so pin-to-pulse is STAGES+1 cycles.
module ttl_fall_detect
    import sn74_sync_pkg::*;
#(
    parameter int STAGES = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic lvl,
    output logic fall
);

    localparam int N = (STAGES > MAX_SYNC_STAGES) ? MAX_SYNC_STAGES : STAGES;

    logic prev_q, prev_d;
    logic fall_q, fall_d;

    generate
        if (N == 0) begin : g_nosync
            assign lvl = pin;
        end else begin : g_sync
            logic [N-1:0] sync_q, sync_d;

            always_comb begin
                sync_d    = sync_q << 1;
                sync_d[0] = pin;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= sync_d;
                end
            end

            assign lvl = sync_q[N-1];
        end
    endgenerate

    // prev resets low, so a pin held low through reset never looks like a fall.
    always_comb begin
        prev_d = lvl;
        fall_d = prev_q & ~lvl;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            fall_q <= fall_d;
        end
    end

    assign fall = fall_q;

endmodule

// File: rtl/sn7493_sync.sv
// SN7493 4-bit ripple counter rebuilt as a single-clock design counting detected pin falls.
// Pin-to-Q latency is EDGE_SYNC_STAGES+2 cycles; clear (both R0 high) overrides any count that cycle.
module sn7493_sync
    import sn74_sync_pkg::*;
#(
    parameter int EDGE_SYNC_STAGES = 0,
    parameter int CHAIN_A_TO_B     = 0
) (
    input  logic CLK_DRV,
    input  logic RST_N,
    input  logic CKA_N,
    input  logic CKB_N,
    input  logic R0_1,
    input  logic R0_2,
    output logic QA,
    output logic QB,
    output logic QC,
    output logic QD
);

    logic lvl_a, fall_a;
    logic lvl_b, fall_b;
    logic lvl_r1, fall_r1;
    logic lvl_r2, fall_r2;
    logic unused_sig;

    count4_t cnt_q, cnt_d;
    logic    t_a, t_b, t_c, t_d;
    logic    clr;

    ttl_fall_detect #(.STAGES(EDGE_SYNC_STAGES)) u_det_a (
        .clk(CLK_DRV), .rst_n(RST_N), .pin(CKA_N), .lvl(lvl_a), .fall(fall_a)
    );

    ttl_fall_detect #(.STAGES(EDGE_SYNC_STAGES)) u_det_b (
        .clk(CLK_DRV), .rst_n(RST_N), .pin(CKB_N), .lvl(lvl_b), .fall(fall_b)
    );

    ttl_fall_detect #(.STAGES(EDGE_SYNC_STAGES)) u_det_r1 (
        .clk(CLK_DRV), .rst_n(RST_N), .pin(R0_1), .lvl(lvl_r1), .fall(fall_r1)
    );

    ttl_fall_detect #(.STAGES(EDGE_SYNC_STAGES)) u_det_r2 (
        .clk(CLK_DRV), .rst_n(RST_N), .pin(R0_2), .lvl(lvl_r2), .fall(fall_r2)
    );

    assign unused_sig = ^{lvl_a, lvl_b, fall_r1, fall_r2};

    // The whole ripple resolves in one cycle: each stage toggles when all lower stages carry.
    always_comb begin
        clr   = lvl_r1 & lvl_r2;
        t_a   = fall_a;
        t_b   = (CHAIN_A_TO_B != 0) ? (fall_a & cnt_q[0]) : fall_b;
        t_c   = t_b & cnt_q[1];
        t_d   = t_c & cnt_q[2];
        cnt_d = cnt_q ^ {t_d, t_c, t_b, t_a};
        if (clr) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK_DRV or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign QA = cnt_q[0];
    assign QB = cnt_q[1];
    assign QC = cnt_q[2];
    assign QD = cnt_q[3];

endmodule

// File: tb/tb_sn7493_sync.sv
module tb_sn7493_sync;

    logic clk;
    logic rst_n;

    // chained, no synchronizer
    logic a_cka, a_ckb, a_r1, a_r2;
    logic a_qa, a_qb, a_qc, a_qd;
    // independent stages, no synchronizer
    logic b_cka, b_ckb, b_r1, b_r2;
    logic b_qa, b_qb, b_qc, b_qd;
    // chained, two synchronizer stages
    logic c_cka, c_ckb, c_r1, c_r2;
    logic c_qa, c_qb, c_qc, c_qd;

    logic [3:0] q_chain, q_sep, q_sync;
    assign q_chain = {a_qd, a_qc, a_qb, a_qa};
    assign q_sep   = {b_qd, b_qc, b_qb, b_qa};
    assign q_sync  = {c_qd, c_qc, c_qb, c_qa};

    int n_tests = 0;
    int n_fail  = 0;

    sn7493_sync #(.EDGE_SYNC_STAGES(0), .CHAIN_A_TO_B(1)) u_chain (
        .CLK_DRV(clk), .RST_N(rst_n), .CKA_N(a_cka), .CKB_N(a_ckb),
        .R0_1(a_r1), .R0_2(a_r2), .QA(a_qa), .QB(a_qb), .QC(a_qc), .QD(a_qd)
    );

    sn7493_sync #(.EDGE_SYNC_STAGES(0), .CHAIN_A_TO_B(0)) u_sep (
        .CLK_DRV(clk), .RST_N(rst_n), .CKA_N(b_cka), .CKB_N(b_ckb),
        .R0_1(b_r1), .R0_2(b_r2), .QA(b_qa), .QB(b_qb), .QC(b_qc), .QD(b_qd)
    );

    sn7493_sync #(.EDGE_SYNC_STAGES(2), .CHAIN_A_TO_B(1)) u_sync (
        .CLK_DRV(clk), .RST_N(rst_n), .CKA_N(c_cka), .CKB_N(c_ckb),
        .R0_1(c_r1), .R0_2(c_r2), .QA(c_qa), .QB(c_qb), .QC(c_qc), .QD(c_qd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_cka = 1'b1; a_ckb = 1'b1; a_r1 = 1'b0; a_r2 = 1'b0;
        b_cka = 1'b1; b_ckb = 1'b1; b_r1 = 1'b0; b_r2 = 1'b0;
        c_cka = 1'b1; c_ckb = 1'b1; c_r1 = 1'b0; c_r2 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            a_cka = ~a_cka;
            c_cka = ~c_cka;
            n_tests++;
            if ({q_chain, q_sep, q_sync} !== 12'h000) begin
                n_fail++;
                $display("FAIL reset_hold cyc %0d: got %b/%b/%b want 0000", i, q_chain, q_sep, q_sync);
            end
        end
        a_cka = 1'b0;
        c_cka = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        wait_neg(5);
        n_tests++;
        if (q_chain !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_low_pin: got %b want 0000", q_chain);
        end
        // pin rises: still no count
        a_cka = 1'b1;
        wait_neg(3);
        n_tests++;
        if (q_chain !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_rise_no_count: got %b want 0000", q_chain);
        end
    endtask

    task automatic test_chain_count();
        logic [3:0] exp_v;
        for (int i = 0; i < 16; i++) begin
            exp_v = 4'(i + 1);
            a_cka = 1'b0;
            @(negedge clk);
            n_tests++;
            if (q_chain !== 4'(i)) begin
                n_fail++;
                $display("FAIL chain_early step %0d: got %b want %b", i, q_chain, 4'(i));
            end
            @(negedge clk);
            n_tests++;
            if (q_chain !== exp_v) begin
                n_fail++;
                $display("FAIL chain_step %0d: got %b want %b", i, q_chain, exp_v);
            end
            a_cka = 1'b1;
            wait_neg(2);
        end
    endtask

    task automatic fall_b(input logic do_a, input logic do_b);
        if (do_a) b_cka = 1'b0;
        if (do_b) b_ckb = 1'b0;
        wait_neg(2);
        b_cka = 1'b1;
        b_ckb = 1'b1;
        wait_neg(2);
    endtask

    task automatic test_sep_count();
        logic [3:0] exp_v;
        for (int i = 0; i < 9; i++) begin
            fall_b(1'b0, 1'b1);
            exp_v = {3'((i + 1) % 8), 1'b0};
            n_tests++;
            if (q_sep !== exp_v) begin
                n_fail++;
                $display("FAIL sep_count edge %0d: got %b want %b", i, q_sep, exp_v);
            end
        end
    endtask

    task automatic test_simultaneous();
        fall_b(1'b1, 1'b0);
        fall_b(1'b0, 1'b1);
        fall_b(1'b0, 1'b1);
        n_tests++;
        if (q_sep !== 4'b0111) begin
            n_fail++;
            $display("FAIL simul_setup: got %b want 0111", q_sep);
        end
        b_cka = 1'b0;
        b_ckb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (q_sep !== 4'b1000) begin
            n_fail++;
            $display("FAIL simul_fall: got %b want 1000", q_sep);
        end
        b_cka = 1'b1;
        b_ckb = 1'b1;
        wait_neg(2);
    endtask

    task automatic test_clear();
        b_r1 = 1'b1;
        b_r2 = 1'b1;
        @(negedge clk);
        n_tests++;
        if (q_sep !== 4'b0000) begin
            n_fail++;
            $display("FAIL clear_apply: got %b want 0000", q_sep);
        end
        // this fall is detected during the last clear cycle and must be dropped
        b_ckb = 1'b0;
        wait_neg(2);
        b_r1 = 1'b0;
        b_r2 = 1'b0;
        wait_neg(3);
        n_tests++;
        if (q_sep !== 4'b0000) begin
            n_fail++;
            $display("FAIL clear_edge_lost: got %b want 0000", q_sep);
        end
        b_ckb = 1'b1;
        wait_neg(2);
        fall_b(1'b0, 1'b1);
        n_tests++;
        if (q_sep !== 4'b0010) begin
            n_fail++;
            $display("FAIL clear_resume: got %b want 0010", q_sep);
        end
        b_r1 = 1'b1;
        fall_b(1'b0, 1'b1);
        n_tests++;
        if (q_sep !== 4'b0100) begin
            n_fail++;
            $display("FAIL r0_single_no_clear: got %b want 0100", q_sep);
        end
        b_r1 = 1'b0;
    endtask

    task automatic test_sync_latency();
        c_cka = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (q_sync !== 4'b0000) begin
                n_fail++;
                $display("FAIL sync_early cyc %0d: got %b want 0000", i, q_sync);
            end
        end
        @(negedge clk);
        n_tests++;
        if (q_sync !== 4'b0001) begin
            n_fail++;
            $display("FAIL sync_latency4: got %b want 0001", q_sync);
        end
        c_cka = 1'b1;
        wait_neg(3);
        for (int i = 0; i < 10; i++) begin
            c_cka = 1'b0;
            wait_neg(3);
            c_cka = 1'b1;
            wait_neg(3);
        end
        n_tests++;
        if (q_sync !== 4'b1011) begin
            n_fail++;
            $display("FAIL sync_count11: got %b want 1011", q_sync);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({q_chain, q_sep, q_sync} !== 12'h000) begin
            n_fail++;
            $display("FAIL async_reset: got %b/%b/%b want 0000", q_chain, q_sep, q_sync);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_neg(2);
    endtask

    initial begin
        test_reset();
        test_chain_count();
        test_sep_count();
        test_simultaneous();
        test_clear();
        test_sync_latency();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
